twi_frame_assembler: RTL and testbench
======================================

// Module: twi_frame_assembler
// PURPOSE
//  Reverse path of the TWI monitor: collects three consecutive bytes from the UART receiver
//  (address, data, ack byte) and reassembles one 18-bit TWI frame {addr[7:0],addr_ack,data[7:0],data_ack}.
//  Sits between the UART RX byte strobe and the TWI frame consumer (bus driver / replay buffer).
//  Presents the frame with a valid/ready handshake. An inter-byte timeout resynchronises after a lost byte.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  max enabled clk cycles between bytes of one frame before abort (>=2)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  enable       in   1   clock-enable; low freezes state, counter and outputs
//  rx_data      in   8   byte from UART receiver, qualified by rx_valid
//  rx_valid     in   1   one-cycle strobe: rx_data holds a new byte
//  frame        out  18  assembled frame: [17:10] addr, [9] addr_ack, [8:1] data, [0] data_ack
//  frame_valid  out  1   frame holds a complete frame; held until accepted
//  frame_ready  in   1   consumer accepts frame when frame_valid & frame_ready
//  frame_error  out  1   one-cycle pulse: frame aborted (timeout or, with check, bad ack byte)
//  overrun      out  1   one-cycle pulse: byte arrived while a frame was pending and not accepted
//  busy         out  1   high in GOT_ADDR/GOT_DATA (frame partially assembled)
// BEHAVIOUR
//  Reset: state IDLE, frame=0, frame_valid=0, frame_error=0, overrun=0, busy=0, timeout counter=0.
//  enable=0: every register holds; rx_valid ignored (no capture, no overrun); pulse outputs forced 0.
//  The rules below apply only on cycles with enable=1.
//  FSM IDLE -> GOT_ADDR -> GOT_DATA -> PRESENT -> IDLE:
//   IDLE:     rx_valid -> latch rx_data as addr, clear counter, go GOT_ADDR.
//   GOT_ADDR: rx_valid -> latch data byte, clear counter, go GOT_DATA.
//   GOT_DATA: rx_valid -> decode ack byte, load frame register, go PRESENT.
//   PRESENT:  frame_valid=1. frame_ready -> go IDLE.
//  Latency: frame_valid rises on the cycle after the ack-byte rx_valid is sampled.
//  frame changes only on entry to PRESENT. It is stable for as long as frame_valid=1.
//  Same-cycle handshake + rx_valid in PRESENT: the byte is taken as the new addr -> GOT_ADDR, no overrun.
//  rx_valid in PRESENT without frame_ready: byte dropped, overrun pulses, state stays PRESENT.
//  Timeout: counter increments in GOT_ADDR/GOT_DATA. Reaching TIMEOUT_CYCLES-1 with no rx_valid ->
//   IDLE, frame_error pulse, partial bytes discarded. rx_valid on that same cycle wins (no timeout).
//  Counter width $clog2(TIMEOUT_CYCLES). Counter saturates; it never wraps.
//  Ack decode (default): addr_ack=rx_data[4], data_ack=rx_data[0].
//  reset mid-frame or in PRESENT: immediate return to reset values; pending frame lost.
// CONFIGURATION
//  FRAME_ACK_CHECK_EN defined: the ack byte must be nibble-replicated ({4{a},4{d}}: 8'h00/0F/F0/FF).
//   Any other value -> frame dropped, frame_error pulses, IDLE, frame register unchanged.
//  FRAME_ACK_CHECK_EN undefined: no check; bits [4] and [0] are used, other bits ignored.
// STRUCTURE
//  Shared package twi_monitor_pkg: the frame layout localparams (ADDR_MSB=17, ADDR_ACK=9, DATA_MSB=8,
//   DATA_ACK=0, FRAME_W=18), the state enum type, and the function that packs the ack byte and its
//   inverse checker. The presenter and this assembler both use these.
//  One sub-module: twi_byte_timeout, a clearable saturating counter that asserts expired at TIMEOUT_CYCLES-1.
// TESTING
//  1 bytes 8'h22,8'h77,8'hF0 with 3 idle cycles between -> frame={8'h22,1,8'h77,0}, valid 1 cyc after 3rd.
//  2 frame_ready held 0 for 5 cycles, then 1 -> frame stable for all 5, valid drops the next cycle.
//  3 8'h53 then no byte for TIMEOUT_CYCLES (bench overrides it to 16) -> frame_error pulse at cycle 15, IDLE.
//    Then 8'h16,8'h11,8'hFF -> frame={8'h16,1,8'h11,1}.
//  4 frame pending, byte 8'hAA without ready -> overrun pulse, frame unchanged.
//    Byte 8'hCC with ready on the same cycle -> no overrun, busy=1 (GOT_ADDR).
//  5 enable=0 for 4 cycles in GOT_DATA with rx_valid pulses and a short timeout -> no capture, no timeout.
//    enable=1 then resumes the frame normally.
//  6 FRAME_ACK_CHECK_EN: ack byte 8'h5A -> frame_error, no frame_valid.
//    Without the macro: 8'h5A -> frame_valid with addr_ack=1, data_ack=0.
//    reset asserted in GOT_DATA -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/twi_monitor_pkg.sv
// Shared TWI monitor definitions: frame layout, assembler state type and
// ack-byte packing helpers used by both the presenter and the assembler.
package twi_monitor_pkg;

    localparam int FRAME_W  = 18;
    localparam int ADDR_MSB = 17;
    localparam int ADDR_ACK = 9;
    localparam int DATA_MSB = 8;
    localparam int DATA_ACK = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GOT_ADDR,
        ST_GOT_DATA,
        ST_PRESENT
    } twi_frame_state_t;

    // Ack byte on the wire: each ack bit replicated across one nibble.
    function automatic logic [7:0] pack_ack_byte(input logic addr_ack, input logic data_ack);
        return {{4{addr_ack}}, {4{data_ack}}};
    endfunction

    // True when the byte is one of the four legal nibble-replicated encodings.
    function automatic logic ack_byte_ok(input logic [7:0] ack_byte);
        return ack_byte == pack_ack_byte(ack_byte[4], ack_byte[0]);
    endfunction

endpackage

// File: rtl/twi_byte_timeout.sv
// Clearable saturating inter-byte counter; expired flags TIMEOUT_CYCLES-1.
module twi_byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count enabled cycles while armed; stop at LAST instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            if (clear) begin
                count <= '0;
            end else if (count_en && count != LAST) begin
                count <= count + 1'b1;
            end
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/twi_frame_assembler.sv
// Rebuilds an 18-bit TWI frame from three UART bytes (addr, data, ack byte)
// and offers it on a valid/ready handshake. Optional ack-byte validation is
// compiled in with FRAME_ACK_CHECK_EN.
module twi_frame_assembler
    import twi_monitor_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               frame_error,
    output logic               overrun,
    output logic               busy
);

    twi_frame_state_t   state;
    twi_frame_state_t   state_next;
    logic [7:0]         addr_q;
    logic [7:0]         data_q;
    logic [FRAME_W-1:0] frame_q;
    logic               error_q;
    logic               overrun_q;
    logic               expired;
    logic               ack_ok;

`ifdef FRAME_ACK_CHECK_EN
    assign ack_ok = ack_byte_ok(rx_data);
`else
    assign ack_ok = 1'b1;
`endif

    twi_byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .clear   (rx_valid | ~busy),
        .count_en(busy),
        .expired (expired)
    );

    // State register; enable low freezes the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    // Next-state: a received byte always beats a same-cycle timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (rx_valid) state_next = ST_GOT_ADDR;
            end
            ST_GOT_ADDR: begin
                if (rx_valid)     state_next = ST_GOT_DATA;
                else if (expired) state_next = ST_IDLE;
            end
            ST_GOT_DATA: begin
                if (rx_valid)     state_next = ack_ok ? ST_PRESENT : ST_IDLE;
                else if (expired) state_next = ST_IDLE;
            end
            ST_PRESENT: begin
                if (frame_ready) state_next = rx_valid ? ST_GOT_ADDR : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        frame_valid = (state == ST_PRESENT);
        busy        = (state == ST_GOT_ADDR) || (state == ST_GOT_DATA);
    end

    // Byte capture, frame load and pulse generation; pulses clear while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            data_q    <= '0;
            frame_q   <= '0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (!enable) begin
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rx_valid) addr_q <= rx_data;
                end
                ST_GOT_ADDR: begin
                    if (rx_valid)     data_q  <= rx_data;
                    else if (expired) error_q <= 1'b1;
                end
                ST_GOT_DATA: begin
                    if (rx_valid) begin
                        if (ack_ok) frame_q <= {addr_q, rx_data[4], data_q, rx_data[0]};
                        else        error_q <= 1'b1;
                    end else if (expired) begin
                        error_q <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (rx_valid) begin
                        if (frame_ready) addr_q    <= rx_data;
                        else             overrun_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign frame       = frame_q;
    assign frame_error = error_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_twi_frame_assembler.sv
// Self-checking bench for twi_frame_assembler: directed scenarios followed by
// randomized traffic, all compared each cycle against a byte-queue model.
module tb_twi_frame_assembler;

    localparam int unsigned TC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [17:0] frame;
    logic        frame_valid;
    logic        frame_ready;
    logic        frame_error;
    logic        overrun;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: bytes of the frame in progress, idle gap,
    // pending frame and expected pulses.
    logic [7:0]  m_q[$];
    int          m_gap = 0;
    bit          m_valid = 0;
    logic [17:0] m_frame = '0;
    bit          m_err = 0;
    bit          m_ovr = 0;

    always #5 clk = ~clk;

    twi_frame_assembler #(
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame      (frame),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_error(frame_error),
        .overrun    (overrun),
        .busy       (busy)
    );

    function automatic bit ack_legal(input logic [7:0] b);
`ifdef FRAME_ACK_CHECK_EN
        return (b == 8'h00) || (b == 8'h0F) || (b == 8'hF0) || (b == 8'hFF);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [7:0] ab;
        if (reset) begin
            m_q.delete();
            m_gap   = 0;
            m_valid = 0;
            m_frame = '0;
            m_err   = 0;
            m_ovr   = 0;
        end else if (!enable) begin
            m_err = 0;
            m_ovr = 0;
        end else begin
            m_err = 0;
            m_ovr = 0;
            if (m_valid) begin
                if (frame_ready) begin
                    m_valid = 0;
                    if (rx_valid) begin
                        m_q.push_back(rx_data);
                        m_gap = 0;
                    end
                end else if (rx_valid) begin
                    m_ovr = 1;
                end
            end else if (rx_valid) begin
                m_q.push_back(rx_data);
                m_gap = 0;
                if (m_q.size() == 3) begin
                    ab = m_q[2];
                    if (ack_legal(ab)) begin
                        m_frame = {m_q[0], ab[4], m_q[1], ab[0]};
                        m_valid = 1;
                    end else begin
                        m_err = 1;
                    end
                    m_q.delete();
                end
            end else if (m_q.size() > 0) begin
                m_gap++;
                if (m_gap >= int'(TC)) begin
                    m_err = 1;
                    m_q.delete();
                    m_gap = 0;
                end
            end
        end
    endtask

    task automatic cycle(input string tag, input logic rst, input logic en, input logic rv,
                         input logic [7:0] d, input logic rdy);
        reset       = rst;
        enable      = en;
        rx_valid    = rv;
        rx_data     = d;
        frame_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".frame"}, frame, m_frame);
        check({tag, ".valid"}, {17'b0, frame_valid}, {17'b0, m_valid});
        check({tag, ".error"}, {17'b0, frame_error}, {17'b0, m_err});
        check({tag, ".overrun"}, {17'b0, overrun}, {17'b0, m_ovr});
        check({tag, ".busy"}, {17'b0, busy}, {17'b0, (m_q.size() > 0)});
    endtask

    task automatic send(input string tag, input logic [7:0] b, input logic rdy);
        cycle(tag, 1'b0, 1'b1, 1'b1, b, rdy);
    endtask

    task automatic idle(input string tag, input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b1, 1'b0, 8'h00, rdy);
    endtask

    initial begin
        logic [7:0] acks[4];
        acks[0] = 8'h00; acks[1] = 8'h0F; acks[2] = 8'hF0; acks[3] = 8'hFF;

        // Reset values
        cycle("reset", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle("reset", 1'b1, 1'b0, 1'b1, 8'h55, 1'b1);

        // Basic frame with idle gaps between bytes
        send("t1", 8'h22, 1'b0);
        idle("t1", 3, 1'b0);
        send("t1", 8'h77, 1'b0);
        idle("t1", 3, 1'b0);
        send("t1", 8'hF0, 1'b0);
        check("t1.const_frame", frame, {8'h22, 1'b1, 8'h77, 1'b0});
        check("t1.const_valid", {17'b0, frame_valid}, 18'd1);

        // Backpressure: frame held while ready is low
        idle("t2", 5, 1'b0);
        idle("t2", 1, 1'b1);
        check("t2.const_valid_drop", {17'b0, frame_valid}, 18'd0);

        // Timeout after a lone address byte, then a good frame
        send("t3", 8'h53, 1'b0);
        idle("t3", int'(TC) - 1, 1'b0);
        check("t3.const_no_err_yet", {17'b0, frame_error}, 18'd0);
        idle("t3", 1, 1'b0);
        check("t3.const_err", {17'b0, frame_error}, 18'd1);
        check("t3.const_idle", {17'b0, busy}, 18'd0);
        send("t3", 8'h16, 1'b0);
        send("t3", 8'h11, 1'b0);
        send("t3", 8'hFF, 1'b0);
        check("t3.const_frame", frame, {8'h16, 1'b1, 8'h11, 1'b1});

        // Overrun while pending, then same-cycle handshake and new address
        send("t4", 8'hAA, 1'b0);
        check("t4.const_overrun", {17'b0, overrun}, 18'd1);
        send("t4", 8'hCC, 1'b1);
        check("t4.const_busy", {17'b0, busy}, 18'd1);
        check("t4.const_no_overrun", {17'b0, overrun}, 18'd0);

        // Freeze in GOT_DATA: strobes ignored, timeout paused
        send("t5", 8'h3C, 1'b0);
        idle("t5", 12, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle("t5.frozen", 1'b0, 1'b0, (i % 2 == 0), 8'h0F, 1'b0);
        idle("t5", 2, 1'b0);
        send("t5", 8'h0F, 1'b0);
        check("t5.const_frame", frame, {8'hCC, 1'b0, 8'h3C, 1'b1});
        idle("t5", 1, 1'b1);

        // Irregular ack byte
        send("t6", 8'h81, 1'b0);
        send("t6", 8'h42, 1'b0);
        send("t6", 8'h5A, 1'b0);
`ifdef FRAME_ACK_CHECK_EN
        check("t6.const_err", {17'b0, frame_error}, 18'd1);
        check("t6.const_frame_kept", frame, {8'hCC, 1'b0, 8'h3C, 1'b1});
`else
        check("t6.const_frame", frame, {8'h81, 1'b1, 8'h42, 1'b0});
        idle("t6", 1, 1'b1);
`endif

        // Reset in GOT_DATA
        send("t7", 8'h12, 1'b0);
        send("t7", 8'h34, 1'b0);
        cycle("t7.reset", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        check("t7.const_frame", frame, 18'd0);

        // Randomized traffic, occasionally with gaps long enough to time out
        for (int n = 0; n < 600; n++) begin
            logic       rst;
            logic       en;
            logic       rv;
            logic [7:0] b;
            if ($urandom_range(0, 60) == 0) begin
                idle("rand.gap", int'($urandom_range(TC - 2, TC + 2)), 1'b0);
            end
            rst = ($urandom_range(0, 150) == 0);
            en  = ($urandom_range(0, 7) != 0);
            rv  = ($urandom_range(0, 2) == 0);
            if (m_q.size() == 2 && $urandom_range(0, 3) != 0)
                b = acks[$urandom_range(0, 3)];
            else
                b = 8'($urandom);
            cycle("rand", rst, en, rv, b, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
